serial_frame_rx: RTL and testbench

//  Parametrised serial frame receiver: start bit (0), DATA_W data bits MSB-first, optional parity,

---
 rtl/serial_frame_rx_if.sv | 25 ++
 rtl/serial_frame_rx.sv | 165 ++++++++++++++++
 tb/tb_serial_frame_rx.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/serial_frame_rx_if.sv
// Port bundle for serial_frame_rx: bit strobe and serial line in, FIFO read port and status out.
// The slave modport is the receiver's view; the master modport is the driving/consuming side.
interface serial_frame_rx_if #(
  parameter int DATA_W     = 9,
  parameter int FIFO_DEPTH = 4
);
  logic                        i_sample_en;
  logic                        i_ser_in;
  logic                        i_ready_in;
  logic [DATA_W-1:0]           o_data_out;
  logic                        o_valid_out;
  logic                        o_frame_err;
  logic                        o_overrun;
  logic [$clog2(FIFO_DEPTH):0] o_fifo_level;

  modport slave (
    input  i_sample_en, i_ser_in, i_ready_in,
    output o_data_out, o_valid_out, o_frame_err, o_overrun, o_fifo_level
  );

  modport master (
    output i_sample_en, i_ser_in, i_ready_in,
    input  o_data_out, o_valid_out, o_frame_err, o_overrun, o_fifo_level
  );
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver (start, DATA_W bits MSB-first, STOP_BITS stop) feeding a circular output FIFO.
// Define FRAME_PARITY_EN to add one parity bit (even/odd per PARITY_ODD) after the data bits.
module serial_frame_rx #(
  parameter int DATA_W     = 9,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int PARITY_ODD = 0
) (
  input  logic             i_synced_clk,
  input  logic             i_rst_n,
  serial_frame_rx_if.slave bus
);

  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(DATA_W) + 1;

`ifdef FRAME_PARITY_EN
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_DATA, S_STOP} state_t;
`endif

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [DATA_W-1:0]  r_shift, w_shift_nxt;
  logic               r_frame_err;
  logic               r_overrun;
  logic               w_push;
  logic               w_ferr;

  logic [DATA_W-1:0]  r_mem [FIFO_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [AW:0]        r_level;
  logic               w_full;
  logic               w_pop;
  logic               w_wr;

`ifdef FRAME_PARITY_EN
  logic r_perr, w_perr_nxt;
  logic w_par_exp;

  assign w_par_exp = (^r_shift) ^ (PARITY_ODD != 0);
`endif

  always_ff @(negedge i_synced_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_shift     <= '0;
      r_frame_err <= 1'b0;
`ifdef FRAME_PARITY_EN
      r_perr      <= 1'b0;
`endif
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_shift     <= w_shift_nxt;
      r_frame_err <= w_ferr;
`ifdef FRAME_PARITY_EN
      r_perr      <= w_perr_nxt;
`endif
    end
  end

  // A bad (0) stop bit returns to IDLE without being treated as the next start bit.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_shift_nxt = r_shift;
    w_push      = 1'b0;
    w_ferr      = 1'b0;
`ifdef FRAME_PARITY_EN
    w_perr_nxt  = r_perr;
`endif
    if (bus.i_sample_en) begin
      case (r_state)
        S_IDLE: begin
          if (!bus.i_ser_in) begin
            w_state_nxt = S_DATA;
            w_cnt_nxt   = '0;
`ifdef FRAME_PARITY_EN
            w_perr_nxt  = 1'b0;
`endif
          end
        end
        S_DATA: begin
          w_shift_nxt = {r_shift[DATA_W-2:0], bus.i_ser_in};
          w_cnt_nxt   = r_cnt + CNT_W'(1);
          if (r_cnt == CNT_W'(DATA_W - 1)) begin
            w_cnt_nxt   = '0;
`ifdef FRAME_PARITY_EN
            w_state_nxt = S_PARITY;
`else
            w_state_nxt = S_STOP;
`endif
          end
        end
`ifdef FRAME_PARITY_EN
        S_PARITY: begin
          w_perr_nxt  = (bus.i_ser_in != w_par_exp);
          w_state_nxt = S_STOP;
          w_cnt_nxt   = '0;
        end
`endif
        S_STOP: begin
          if (!bus.i_ser_in) begin
            w_ferr      = 1'b1;
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else if (r_cnt == CNT_W'(STOP_BITS - 1)) begin
`ifdef FRAME_PARITY_EN
            w_ferr      = r_perr;
            w_push      = !r_perr;
`else
            w_push      = 1'b1;
`endif
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  // A push into a full FIFO still lands if the head is popped on the same edge.
  assign w_full = (r_level == (AW+1)'(FIFO_DEPTH));
  assign w_pop  = (r_level != '0) && bus.i_ready_in;
  assign w_wr   = w_push && (!w_full || w_pop);

  always_ff @(negedge i_synced_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= w_push && w_full && !w_pop;
      if (w_wr) begin
        r_mem[r_wr_ptr] <= r_shift;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_level <= r_level + (AW+1)'(1);
        2'b01:   r_level <= r_level - (AW+1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  assign bus.o_data_out   = r_mem[r_rd_ptr];
  assign bus.o_valid_out  = (r_level != '0);
  assign bus.o_frame_err  = r_frame_err;
  assign bus.o_overrun    = r_overrun;
  assign bus.o_fifo_level = r_level;

endmodule

// File: tb/tb_serial_frame_rx.sv
// Testbench for serial_frame_rx: table-driven frame vectors, hand-written corner sequences and
// randomized frames checked every clock against a queue-based model of the receiver and FIFO.
module tb_serial_frame_rx;

  localparam int DATA_W     = 9;
  localparam int STOP_BITS  = 1;
  localparam int FIFO_DEPTH = 4;
  localparam int PARITY_ODD = 0;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  serial_frame_rx_if #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) bus ();

  serial_frame_rx #(
    .DATA_W(DATA_W), .STOP_BITS(STOP_BITS), .FIFO_DEPTH(FIFO_DEPTH), .PARITY_ODD(PARITY_ODD)
  ) dut (
    .i_synced_clk(clk),
    .i_rst_n     (rst_n),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int compared   = 0;
  int mismatched = 0;

  logic [DATA_W-1:0] modelQ[$];
  bit                expErr;
  bit                expOvr;

  typedef struct {
    logic [DATA_W-1:0] word;
    bit                stopGood;
    int                expLevel;
    bit                expErr;
    bit                expOvr;
  } vec_t;

  vec_t vecs[6];

  task automatic compareVal(input string name, input logic [31:0] actual, input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput();
    compareVal("valid", 32'(bus.o_valid_out), 32'(modelQ.size() != 0));
    compareVal("level", 32'(bus.o_fifo_level), 32'(modelQ.size()));
    compareVal("frame_err", 32'(bus.o_frame_err), 32'(expErr));
    compareVal("overrun", 32'(bus.o_overrun), 32'(expOvr));
    if (modelQ.size() != 0) compareVal("data", 32'(bus.o_data_out), 32'(modelQ[0]));
  endtask

  // One clock: drive inputs, let the falling edge happen, advance the model, compare.
  task automatic applyStimulus(input bit se, input bit si, input bit rdy,
                               input bit push, input logic [DATA_W-1:0] word, input bit ferr);
    bit pop;
    bit full;
    bus.i_sample_en = se;
    bus.i_ser_in    = si;
    bus.i_ready_in  = rdy;
    pop  = (modelQ.size() != 0) && rdy;
    full = (modelQ.size() == FIFO_DEPTH);
    @(negedge clk);
    #1;
    expErr = ferr;
    expOvr = 1'b0;
    if (pop) void'(modelQ.pop_front());
    if (push) begin
      if (full && !pop) expOvr = 1'b1;
      else modelQ.push_back(word);
    end
    checkOutput();
  endtask

  function automatic bit readyFor(input int mode, input bit isLast);
    case (mode)
      0:       return 1'b0;
      1:       return 1'b1;
      2:       return bit'($urandom_range(0, 1));
      default: return isLast;
    endcase
  endfunction

  task automatic idle(input int n, input int mode);
    for (int i = 0; i < n; i++) applyStimulus(1'b1, 1'b1, readyFor(mode, 1'b0), 1'b0, '0, 1'b0);
  endtask

  // mode: 0 ready low, 1 ready high, 2 random ready, 3 ready only on the final bit.
  task automatic sendFrame(input logic [DATA_W-1:0] word, input bit stopGood, input bit parityGood,
                           input int mode, input bit gaps);
    bit bits[$];
    int last;
    bit good;
    bit isLast;
    bits.delete();
    bits.push_back(1'b0);
    for (int i = DATA_W - 1; i >= 0; i--) bits.push_back(word[i]);
`ifdef FRAME_PARITY_EN
    bits.push_back((^word) ^ (PARITY_ODD != 0) ^ !parityGood);
`endif
    for (int s = 0; s < STOP_BITS; s++) bits.push_back(stopGood || (s != 0));
    last = stopGood ? bits.size() - 1 : bits.size() - STOP_BITS;
    good = stopGood && parityGood;
    for (int i = 0; i <= last; i++) begin
      if (gaps && ($urandom_range(0, 2) == 0))
        applyStimulus(1'b0, bit'($urandom_range(0, 1)), readyFor(mode, 1'b0), 1'b0, '0, 1'b0);
      isLast = (i == last);
      applyStimulus(1'b1, bits[i], readyFor(mode, isLast), isLast && good, word, isLast && !good);
    end
  endtask

  initial begin
    vecs[0] = '{word: 9'h001, stopGood: 1'b1, expLevel: 1, expErr: 1'b0, expOvr: 1'b0};
    vecs[1] = '{word: 9'h002, stopGood: 1'b1, expLevel: 2, expErr: 1'b0, expOvr: 1'b0};
    vecs[2] = '{word: 9'h003, stopGood: 1'b1, expLevel: 3, expErr: 1'b0, expOvr: 1'b0};
    vecs[3] = '{word: 9'h004, stopGood: 1'b1, expLevel: 4, expErr: 1'b0, expOvr: 1'b0};
    vecs[4] = '{word: 9'h005, stopGood: 1'b1, expLevel: 4, expErr: 1'b0, expOvr: 1'b1};
    vecs[5] = '{word: 9'h0AA, stopGood: 1'b0, expLevel: 4, expErr: 1'b1, expOvr: 1'b0};

    bus.i_sample_en = 1'b0;
    bus.i_ser_in    = 1'b1;
    bus.i_ready_in  = 1'b0;
    expErr = 1'b0;
    expOvr = 1'b0;

    #1 rst_n = 1'b0;
    #2 checkOutput();
    @(negedge clk);
    #3 rst_n = 1'b1;
    idle(3, 1);

    $display("[TB] single frame 0x169 with ready high");
    sendFrame(9'h169, 1'b1, 1'b1, 1, 1'b0);
    compareVal("t1_data", 32'(bus.o_data_out), 32'h169);
    compareVal("t1_level_after_push", 32'(bus.o_fifo_level), 32'd1);
    idle(1, 1);
    compareVal("t1_level_after_pop", 32'(bus.o_fifo_level), 32'd0);

    $display("[TB] vector table: fill, overrun, bad stop bit while full");
    for (int i = 0; i < 6; i++) begin
      sendFrame(vecs[i].word, vecs[i].stopGood, 1'b1, 0, 1'b0);
      compareVal("tbl_level", 32'(bus.o_fifo_level), 32'(vecs[i].expLevel));
      compareVal("tbl_frame_err", 32'(bus.o_frame_err), 32'(vecs[i].expErr));
      compareVal("tbl_overrun", 32'(bus.o_overrun), 32'(vecs[i].expOvr));
      idle(2, 0);
    end
    for (int k = 1; k <= 4; k++) begin
      compareVal("t2_order", 32'(bus.o_data_out), 32'(k));
      idle(1, 1);
    end
    compareVal("t2_drained", 32'(bus.o_fifo_level), 32'd0);

    $display("[TB] bad stop bit followed back-to-back by a good frame");
    sendFrame(9'h155, 1'b0, 1'b1, 0, 1'b0);
    sendFrame(9'h0AA, 1'b1, 1'b1, 0, 1'b0);
    compareVal("t3_data", 32'(bus.o_data_out), 32'h0AA);
    idle(2, 1);

    $display("[TB] full FIFO with pop on the completing edge");
    for (int k = 0; k < 4; k++) sendFrame(DATA_W'(9'h010 + k), 1'b1, 1'b1, 0, 1'b0);
    sendFrame(9'h1FF, 1'b1, 1'b1, 3, 1'b0);
    compareVal("t4_level", 32'(bus.o_fifo_level), 32'd4);
    compareVal("t4_overrun", 32'(bus.o_overrun), 32'd0);
    compareVal("t4_head", 32'(bus.o_data_out), 32'h011);
    idle(6, 1);

    $display("[TB] asynchronous reset mid-frame");
    sendFrame(9'h0F0, 1'b1, 1'b1, 0, 1'b0);
    sendFrame(9'h00F, 1'b1, 1'b1, 0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, '0, 1'b0);
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    modelQ.delete();
    compareVal("t5_valid", 32'(bus.o_valid_out), 32'd0);
    compareVal("t5_level", 32'(bus.o_fifo_level), 32'd0);
    compareVal("t5_data", 32'(bus.o_data_out), 32'd0);
    compareVal("t5_frame_err", 32'(bus.o_frame_err), 32'd0);
    compareVal("t5_overrun", 32'(bus.o_overrun), 32'd0);
    @(negedge clk);
    #3 rst_n = 1'b1;
    expErr = 1'b0;
    expOvr = 1'b0;
    idle(2, 0);
    sendFrame(9'h100, 1'b1, 1'b1, 0, 1'b0);
    compareVal("t5_after_reset", 32'(bus.o_data_out), 32'h100);
    idle(2, 1);

`ifdef FRAME_PARITY_EN
    $display("[TB] parity mismatch rejected, matching parity accepted");
    sendFrame(9'h003, 1'b1, 1'b0, 0, 1'b0);
    compareVal("t6_err", 32'(bus.o_frame_err), 32'd1);
    compareVal("t6_nopush", 32'(bus.o_fifo_level), 32'd0);
    sendFrame(9'h003, 1'b1, 1'b1, 0, 1'b0);
    compareVal("t6_push", 32'(bus.o_data_out), 32'h003);
    idle(2, 1);
`endif

    $display("[TB] randomized frames");
    for (int n = 0; n < 150; n++) begin
      bit pGood;
`ifdef FRAME_PARITY_EN
      pGood = ($urandom_range(0, 7) != 0);
`else
      pGood = 1'b1;
`endif
      sendFrame(DATA_W'($urandom), ($urandom_range(0, 7) != 0), pGood, 2, 1'b1);
      idle($urandom_range(0, 3), 2);
    end
    idle(8, 1);
    compareVal("final_drained", 32'(bus.o_fifo_level), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
